// File: rtl/err_recovery_pkg.sv
// err_recovery_pkg
// Shared definitions for the sequential error-recovery stage: FSM state
// encoding, default parameter values and helpers that derive the chunk
// count and the depth-input width from WIDTH/CHUNK.
package err_recovery_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_CHUNK     = 8;
  localparam int unsigned DEF_ERR_SHIFT = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit word.
  function automatic int unsigned nchunk(input int unsigned width,
                                         input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of the depth input: must encode 0..n inclusive.
  function automatic int unsigned depth_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/err_chunk_add.sv
// err_chunk_add
// One CHUNK-bit slice of the recovery adder.
//   i_a, i_b : approximate-sum chunk and shifted-error chunk
//   i_cin    : carry from the previous (lower) chunk
//   i_en     : 1 = correct this chunk, 0 = pass i_a through untouched
//   o_sum    : result chunk
//   o_cout   : carry out; forced to 0 when disabled so uncorrected chunks
//              never leak a carry into the corrected region
module err_chunk_add
  import err_recovery_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_en,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

  always_comb begin
    o_sum  = i_a;
    o_cout = 1'b0;
    if (i_en) begin
      o_sum  = w_full[CHUNK-1:0];
      o_cout = w_full[CHUNK];
    end
  end

endmodule

// File: rtl/err_recovery_seq.sv
// err_recovery_seq
// Sequential error recovery: adds the shifted error vector back into an
// approximate sum one chunk per cycle (LSB chunk first). Only the top
// in_depth chunks are corrected; lower chunks pass through.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : operand handshake (ready only in IDLE)
//   in_approx/err   : approximate sum and error vector
//   in_depth        : number of top chunks to correct (clamped to NCHUNK)
//   out_valid/ready : result handshake
//   out_result      : recovered word mod 2^WIDTH
//   out_carry       : carry out of the top chunk
//   busy            : high in RUN or DONE
module err_recovery_seq
  import err_recovery_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned CHUNK     = DEF_CHUNK,
  parameter  int unsigned ERR_SHIFT = DEF_ERR_SHIFT,
  localparam int unsigned NCHUNK    = nchunk(WIDTH, CHUNK),
  localparam int unsigned DW        = depth_width(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_approx,
  input  logic [WIDTH-1:0] in_err,
  input  logic [DW-1:0]    in_depth,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             busy
);

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_e, r_res;
  logic [DW-1:0]    r_k, r_skip;
  logic             r_carry, r_valid, r_ocarry;

  logic             w_accept, w_last, w_en, w_cout;
  logic [DW-1:0]    w_dclamp;
  logic [WIDTH-1:0] w_eshift;
  logic [CHUNK-1:0] w_sum;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_k == DW'(NCHUNK - 1));
  // Chunk k is corrected once k reaches NCHUNK-D (the skip count).
  assign w_en     = (r_k >= r_skip);
  assign w_dclamp = (in_depth > DW'(NCHUNK)) ? DW'(NCHUNK) : in_depth;
  assign w_eshift = in_err << ERR_SHIFT;

  err_chunk_add #(.CHUNK(CHUNK)) u_add (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_e[CHUNK-1:0]),
    .i_cin  (r_carry),
    .i_en   (w_en),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Operands shift right so the active chunk is always at bit 0; the result
  // shifts in from the top, so after NCHUNK steps it is fully aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_e      <= '0;
      r_res    <= '0;
      r_k      <= '0;
      r_skip   <= '0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
      r_ocarry <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_approx;
      r_e     <= w_eshift;
      r_skip  <= DW'(NCHUNK) - w_dclamp;
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_e     <= r_e >> CHUNK;
      r_res   <= {w_sum, r_res[WIDTH-1:CHUNK]};
      r_carry <= w_cout;
      r_k     <= r_k + DW'(1);
      if (w_last) begin
        r_valid  <= 1'b1;
        r_ocarry <= w_cout;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_valid;
  assign out_result = r_res;
  assign out_carry  = r_ocarry;

endmodule

// File: tb/tb_err_recovery_seq.sv
module tb_err_recovery_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_approx;
  logic [31:0] in_err;
  logic [2:0]  in_depth;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        busy;

  err_recovery_seq #(.WIDTH(32), .CHUNK(8), .ERR_SHIFT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_approx  (in_approx),
    .in_err     (in_err),
    .in_depth   (in_depth),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc     = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: checks latency on the rising edge of out_valid, checks the
  // presented result every valid cycle, pops on handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          if (!prev_v) fail_now("unexpected_out_valid");
        end else begin
          if (!prev_v) chk("latency", 32'(cyc - sb[0].acc), 32'd4);
          chk("out_result", out_result, sb[0].res);
          chk("out_carry", {31'd0, out_carry}, {31'd0, sb[0].c});
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] e, input logic [2:0] d,
                      input logic [31:0] er, input logic ec, input bit push);
    int unsigned w = 0;
    @(posedge clk); #1;
    in_approx = a; in_err = e; in_depth = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{res: er, c: ec, acc: cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    int unsigned w;
    rst = 1'b1; in_valid = 1'b0; in_approx = '0; in_err = '0; in_depth = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);

    out_ready = 1'b1;
    send(32'h000000FF, 32'h00000001, 3'd4, 32'h00000101, 1'b0, 1'b1);
    send(32'hFFFFFFFF, 32'h00000001, 3'd4, 32'h00000001, 1'b1, 1'b1);
    send(32'h00FF00FF, 32'h01000001, 3'd2, 32'h02FF00FF, 1'b0, 1'b1);
    send(32'h12345678, 32'hFFFFFFFF, 3'd0, 32'h12345678, 1'b0, 1'b1);
    send(32'h12345678, 32'hFFFFFFFF, 3'd7, 32'h12345676, 1'b1, 1'b1);
    drain();

    // Backpressure: hold result in DONE while new operands are offered.
    out_ready = 1'b0;
    send(32'hA5A5A5A5, 32'h00000000, 3'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) fail_now("hold_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_approx = 32'hDEADBEEF; in_err = 32'h1; in_depth = 3'd4; in_valid = 1'b1;
      @(negedge clk);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
      chk("hold_busy",      {31'd0, busy},      32'd1);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (6) @(negedge clk);
    chk("no_hidden_accept", {31'd0, out_valid}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset during RUN with k=2: the word must vanish.
    send(32'h00000055, 32'h00000000, 3'd4, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy",      {31'd0, busy},      32'd0);
    chk("midrun_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h00000001, 32'h00000001, 3'd4, 32'h00000003, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
